// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file and its debug port.
package regfile_pkg;

  localparam int XLEN_DEF = 64;

  typedef enum logic [1:0] {
    DBG_IDLE,
    DBG_WAIT,
    DBG_ACCESS,
    DBG_RESP
  } dbg_state_t;

  function automatic int addr_w(input int nreg);
    return (nreg < 2) ? 1 : $clog2(nreg);
  endfunction

endpackage

// File: rtl/regfile_dbg_fsm.sv
// Debug access sequencer: waits for a write-free cycle, grants one access cycle,
// then pulses ack for exactly one cycle.
module regfile_dbg_fsm
  import regfile_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic dbg_req,
  input  logic any_wr,
  output logic dbg_accept,
  output logic dbg_do_access,
  output logic dbg_ack
);

  dbg_state_t state_reg;
  logic       do_access_reg;
  logic       ack_reg;

  // Request fields are captured in the same cycle the request is taken.
  assign dbg_accept    = (state_reg == DBG_IDLE) && dbg_req;
  assign dbg_do_access = do_access_reg;
  assign dbg_ack       = ack_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= DBG_IDLE;
      do_access_reg <= 1'b0;
      ack_reg       <= 1'b0;
    end else begin
      do_access_reg <= 1'b0;
      ack_reg       <= 1'b0;
      case (state_reg)
        DBG_IDLE: begin
          if (dbg_req) state_reg <= DBG_WAIT;
        end
        DBG_WAIT: begin
          // Functional writeback always wins; debug may wait indefinitely.
          if (!any_wr) begin
            state_reg     <= DBG_ACCESS;
            do_access_reg <= 1'b1;
          end
        end
        DBG_ACCESS: begin
          state_reg <= DBG_RESP;
          ack_reg   <= 1'b1;
        end
        DBG_RESP: begin
          state_reg <= DBG_IDLE;
        end
        default: begin
          state_reg <= DBG_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with hardwired x0, write-to-read bypass,
// per-register busy scoreboard and a handshaked debug access port.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int               XLEN    = XLEN_DEF,
  parameter int               NREG    = 32,
  parameter int               NRD     = 2,
  parameter int               NWR     = 1,
  parameter int               BYPASS  = 1,
  parameter int               RST_IDX = 11,
  parameter logic [XLEN-1:0]  RST_VAL = 8,
  localparam int              AW      = addr_w(NREG)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_addr,
  input  logic                dbg_req,
  input  logic                dbg_we,
  input  logic [AW-1:0]       dbg_addr,
  input  logic [XLEN-1:0]     dbg_wdata,
  output logic                dbg_ack,
  output logic [XLEN-1:0]     dbg_rdata
);

  logic [XLEN-1:0] regs_reg [NREG];
  logic [NREG-1:0] busy_reg;
  logic [NREG-1:0] busy_next;

  logic            dbg_we_reg;
  logic [AW-1:0]   dbg_addr_reg;
  logic [XLEN-1:0] dbg_wdata_reg;
  logic [XLEN-1:0] dbg_rdata_reg;

  logic            any_wr;
  logic            dbg_accept;
  logic            dbg_do_access;

  logic [AW-1:0]   wa [NWR];
  logic [XLEN-1:0] wd [NWR];

  genvar gi;

  generate
    for (gi = 0; gi < NWR; gi++) begin : g_wr
      assign wa[gi] = wr_addr[gi*AW +: AW];
      assign wd[gi] = wr_data[gi*XLEN +: XLEN];
    end
  endgenerate

  assign any_wr    = |wr_en;
  assign dbg_rdata = dbg_rdata_reg;

  regfile_dbg_fsm u_dbg_fsm (
    .clk          (clk),
    .reset        (reset),
    .dbg_req      (dbg_req),
    .any_wr       (any_wr),
    .dbg_accept   (dbg_accept),
    .dbg_do_access(dbg_do_access),
    .dbg_ack      (dbg_ack)
  );

  // Debug request fields, held so dbg_req may drop before the ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dbg_we_reg    <= 1'b0;
      dbg_addr_reg  <= '0;
      dbg_wdata_reg <= '0;
    end else if (dbg_accept) begin
      dbg_we_reg    <= dbg_we;
      dbg_addr_reg  <= dbg_addr;
      dbg_wdata_reg <= dbg_wdata;
    end
  end

  // Functional writes are issued after the debug write so they win on a clash.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) begin
        regs_reg[r] <= (r == RST_IDX) ? RST_VAL : '0;
      end
    end else begin
      if (dbg_do_access && dbg_we_reg && (dbg_addr_reg != '0)) begin
        regs_reg[dbg_addr_reg] <= dbg_wdata_reg;
      end
      for (int k = 0; k < NWR; k++) begin
        if (wr_en[k] && (wa[k] != '0)) begin
          regs_reg[wa[k]] <= wd[k];
        end
      end
    end
  end

  // Debug reads take the stored value, never the bypass path.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dbg_rdata_reg <= '0;
    end else if (dbg_do_access && !dbg_we_reg) begin
      dbg_rdata_reg <= regs_reg[dbg_addr_reg];
    end
  end

  always_comb begin
    busy_next = busy_reg;
    for (int k = 0; k < NWR; k++) begin
      if (wr_en[k]) busy_next[wa[k]] = 1'b0;
    end
    if (alloc_en) busy_next[alloc_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] rd_val_next;
      logic            rd_busy_next;
      logic            wr_hit;

      assign ra = rd_addr[gi*AW +: AW];

      always_comb begin
        rd_val_next = regs_reg[ra];
        wr_hit      = 1'b0;
        if (BYPASS != 0) begin
          for (int k = 0; k < NWR; k++) begin
            if (wr_en[k] && (wa[k] == ra)) begin
              rd_val_next = wd[k];
              wr_hit      = 1'b1;
            end
          end
        end
        if (ra == '0) rd_val_next = '0;
        rd_busy_next = busy_reg[ra];
        // A same-cycle writeback retires the register unless it is re-allocated.
        if (wr_hit && !(alloc_en && (alloc_addr == ra))) rd_busy_next = 1'b0;
      end

      assign rd_data[gi*XLEN +: XLEN] = rd_val_next;
      assign rd_busy[gi]              = rd_busy_next;
    end
  endgenerate

endmodule
